// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the 4-slot TDM receiver
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    // Slot position following the given one; wraps 3 -> 0 naturally in SLOT_W bits
    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/tdm_sync_fsm.sv
// rtl/tdm_sync_fsm.sv - slot tracking, frame-lock FSM and sync error detection
module tdm_sync_fsm
    import tdm_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              sync,
    output logic [SLOT_W-1:0] slot,
    output logic              is_last,
    output logic              locked,
    output logic              sync_err
);

    localparam int CNT_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    state_t            state;
    logic [SLOT_W-1:0] slot_q;
    logic [CNT_W-1:0]  frm_cnt;

    // Slot of the current beat: an accepted SYNC always marks slot 0
    always_comb begin
        slot    = sync ? '0 : slot_q;
        is_last = valid && (state == LOCKED) && (slot == SLOT_W'(SLOTS - 1));
    end

    // Lock FSM, slot counter and registered LOCKED / SYNC_ERR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            slot_q   <= '0;
            frm_cnt  <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (valid) begin
                slot_q <= next_slot(slot);
                case (state)
                    HUNT: begin
                        if (sync) begin
                            frm_cnt <= CNT_W'(1);
                            if (LOCK_FRAMES <= 1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (slot_q == '0) begin
                            if (!sync) begin
                                state   <= HUNT;
                                frm_cnt <= '0;
                            end else if (int'(frm_cnt) + 1 >= LOCK_FRAMES) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                frm_cnt <= frm_cnt + 1'b1;
                            end
                        end else if (sync) begin
                            // SYNC arrived early: this beat becomes slot 0 of a fresh count
                            frm_cnt <= CNT_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (slot_q == '0 && !sync) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                            frm_cnt  <= '0;
                        end else if (slot_q != '0 && sync) begin
                            sync_err <= 1'b1;
                            state    <= CONFIRM;
                            locked   <= 1'b0;
                            frm_cnt  <= CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM demultiplexer with frame-sync lock
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    input  logic             sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_vld,
    output logic             locked,
    output logic             sync_err
);

    logic [SLOT_W-1:0] slot;
    logic              is_last;
    logic [WIDTH-1:0]  shadow [SLOTS];

    tdm_sync_fsm #(
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_sync_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid),
        .sync    (sync),
        .slot    (slot),
        .is_last (is_last),
        .locked  (locked),
        .sync_err(sync_err)
    );

    // Capture every beat into the shadow; publish a whole frame at once on its last slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                shadow[i] <= '0;
            end
            y0        <= '0;
            y1        <= '0;
            y2        <= '0;
            y3        <= '0;
            frame_vld <= 1'b0;
        end else begin
            frame_vld <= is_last;
            if (valid) begin
                shadow[slot] <= d;
            end
            if (is_last) begin
                // Slot 3 comes straight from the lane so the frame lands on this edge
                y0 <= shadow[0];
                y1 <= shadow[1];
                y2 <= shadow[2];
                y3 <= d;
            end
        end
    end

endmodule
